// File: rtl/accum_seq_ctrl_pkg.sv
// Shared types and constants for the accumulator frame sequencer.
// complex_t carries an IEEE-754 single-precision real/imag pair.
package accum_seq_ctrl_pkg;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  localparam complex_t COMPLEX_ZERO = 64'h0;

  localparam int ACC_MIN_CYCLES = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAD
  } seq_state_e;

endpackage

// File: rtl/complex_result_fifo.sv
// First-word-fall-through result FIFO for finished accumulator sums.
// Push and pop may coincide at any occupancy, including full.
module complex_result_fifo
  import accum_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  complex_t      data_i,
  input  logic          pop_i,
  output complex_t      data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  complex_t      mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  logic          do_push;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != FULL) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (do_pop) rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
    if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : COMPLEX_ZERO;
  assign count_o = cnt_q;

endmodule

// File: rtl/accum_seq_ctrl.sv
// Frame sequencer: feeds the streaming complex accumulator, pads short
// frames, fills bubbles and meters frames against result FIFO credit.
module accum_seq_ctrl
  import accum_seq_ctrl_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex_t         in_data,
  output complex_t         acc_in,
  output logic             acc_start,
  output logic             acc_stop,
  input  logic             acc_valid,
  input  complex_t         acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output complex_t         out_data,
  output logic [ID_W-1:0]  out_frame_id,
  output logic             busy,
  output logic             seq_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
  localparam logic [3:0] CYC_MIN = 4'(ACC_MIN_CYCLES);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  complex_t         acc_in_q, acc_in_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             vpend_q, vpend_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  id_q;
  logic             en_q;

  logic [CW-1:0]    occ;
  logic [CW-1:0]    live;
  logic [CW:0]      load;
  logic             credit;
  logic [3:0]       cyc_inc;
  logic [LEN_W-1:0] len;
  logic             fifo_valid;

  always_comb begin
    load = {1'b0, occ} + {1'b0, inflight_q}
         + {{CW{1'b0}}, state_q != S_IDLE};
    credit  = en_q && (load < DEPTH_L);
    cyc_inc = (cyc_q >= CYC_MIN) ? CYC_MIN : cyc_q + 4'd1;
    len     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    state_d  = state_q;
    rem_d    = rem_q;
    cyc_d    = cyc_q;
    acc_in_d = COMPLEX_ZERO;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    in_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = credit;
        if (in_valid && credit) begin
          rem_d    = len - LEN_W'(1);
          cyc_d    = 4'd1;
          acc_in_d = in_data;
          start_d  = 1'b1;
          state_d  = (rem_d != '0) ? S_RUN : S_PAD;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        cyc_d    = cyc_inc;
        if (in_valid) begin
          acc_in_d = in_data;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            stop_d  = (cyc_inc >= CYC_MIN);
            state_d = stop_d ? S_IDLE : S_PAD;
          end
        end
      end
      S_PAD: begin
        cyc_d = cyc_inc;
        if (cyc_inc >= CYC_MIN) begin
          stop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A result already scheduled for push no longer counts as claimable.
  always_comb begin
    live       = inflight_q - CW'(vpend_q);
    vpend_d    = acc_valid && (live != '0);
    err_d      = err_q || (acc_valid && (live == '0));
    inflight_d = inflight_q + CW'(stop_d) - CW'(vpend_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      cyc_q      <= '0;
      inflight_q <= '0;
      acc_in_q   <= COMPLEX_ZERO;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      vpend_q    <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cyc_q      <= cyc_d;
      inflight_q <= inflight_d;
      acc_in_q   <= acc_in_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      vpend_q    <= vpend_d;
      err_q      <= err_d;
      en_q       <= 1'b1;
      if (fifo_valid && out_ready) id_q <= id_q + ID_W'(1);
    end
  end

  complex_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (vpend_q),
    .data_i  (acc_out),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .valid_o (fifo_valid),
    .count_o (occ)
  );

  assign acc_in       = acc_in_q;
  assign acc_start    = start_q;
  assign acc_stop     = stop_q;
  assign out_valid    = fifo_valid;
  assign out_frame_id = id_q;
  assign seq_err      = err_q;
  assign busy = (state_q != S_IDLE) || (inflight_q != '0) || (occ != '0);

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl with a behavioural accumulator
// that sums small integer-valued floats and reports frame lengths.
module tb_accum_seq_ctrl;
  import accum_seq_ctrl_pkg::*;

  localparam logic [63:0] ONE2 = 64'h3F800000_40000000;

  logic        clk;
  logic        reset;
  logic [15:0] cfg_len;
  logic        in_valid;
  logic        in_ready;
  complex_t    in_data;
  complex_t    acc_in;
  logic        acc_start;
  logic        acc_stop;
  logic        acc_valid;
  complex_t    acc_out;
  logic        out_valid;
  logic        out_ready;
  complex_t    out_data;
  logic [7:0]  out_frame_id;
  logic        busy;
  logic        seq_err;

  accum_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_len      (cfg_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .acc_in       (acc_in),
    .acc_start    (acc_start),
    .acc_stop     (acc_stop),
    .acc_valid    (acc_valid),
    .acc_out      (acc_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_frame_id (out_frame_id),
    .busy         (busy),
    .seq_err      (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int f2i(input logic [31:0] f);
    int unsigned m;
    int e;
    if (f == 32'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(p + 127), m[22:0]};
  endfunction

  // Accumulator model: result valid one cycle after stop, data one later.
  logic     mv;
  logic     stray_v;
  bit       run_m;
  int       cnt_m, sre, sim, hre, him;
  int       flen_q[$];
  int       start_cnt = 0;
  bit       err_m = 0;

  assign acc_valid = mv | stray_v;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv      <= 1'b0;
      acc_out <= COMPLEX_ZERO;
      run_m   <= 1'b0;
      cnt_m   <= 0;
      sre     <= 0;
      sim     <= 0;
    end else begin
      mv <= acc_stop;
      if (mv) acc_out <= {i2f(hre), i2f(him)};
      if (acc_start) begin
        run_m <= 1'b1;
        cnt_m <= 1;
        sre   <= f2i(acc_in.re);
        sim   <= f2i(acc_in.im);
      end else if (run_m) begin
        cnt_m <= cnt_m + 1;
        sre   <= sre + f2i(acc_in.re);
        sim   <= sim + f2i(acc_in.im);
      end
      if (acc_stop) begin
        run_m <= 1'b0;
        hre   <= sre + f2i(acc_in.re);
        him   <= sim + f2i(acc_in.im);
        flen_q.push_back(cnt_m + 1);
      end
    end
  end

  always @(posedge clk) begin
    if (acc_start) start_cnt <= start_cnt + 1;
    if ((acc_start && run_m) || (acc_stop && !run_m)) err_m <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds n beats; cfg_len is scrambled after the first beat.
  task automatic send_frame(input int len, input int n, input int gap,
                            input int budget, output bit ok);
    ok = 1'b1;
    cfg_len = 16'(len);
    for (int b = 0; b < n; b++) begin
      int w = 0;
      if (b > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      in_valid = 1'b1;
      in_data  = ONE2;
      while (!in_ready && w < budget) begin
        tick();
        w++;
      end
      if (!in_ready) begin
        ok = 1'b0;
        in_valid = 1'b0;
        return;
      end
      tick();
      if (b == 0) begin
        chk("acc_start", acc_start, 1);
        cfg_len = 16'd3;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit ok);
    int w = 0;
    while (!out_valid && w < budget) begin
      tick();
      w++;
    end
    ok = out_valid;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          len;
    int          n;
    int          gap;
    bit          rdy;
    int          cyc;
    logic [63:0] res;
  } vec_t;

  vec_t tbl [5];
  bit   ok, ok1, ok2, seen;
  int   fl;

  initial begin
    tbl[0] = '{16, 16, 0, 1'b1, 16, 64'h41800000_42000000};
    tbl[1] = '{5, 5, 0, 1'b0, 12, 64'h40A00000_41200000};
    tbl[2] = '{12, 12, 1, 1'b1, 23, 64'h41400000_41C00000};
    tbl[3] = '{0, 1, 0, 1'b0, 12, ONE2};
    tbl[4] = '{13, 13, 0, 1'b1, 13, 64'h41500000_41D00000};

    reset = 1'b1; in_valid = 1'b0; in_data = COMPLEX_ZERO;
    cfg_len = '0; out_ready = 1'b0; stray_v = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_acc_stop", acc_stop, 0);
    chk("rst_acc_in", acc_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_frame_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_err", seq_err, 0);
    #10 reset = 1'b1;
    tick();

    for (int r = 0; r < 5; r++) begin
      send_frame(tbl[r].len, tbl[r].n, tbl[r].gap, 50, ok);
      chk("accepted", ok, 1);
      chk("rdy_after_last", in_ready, tbl[r].rdy);
      wait_out(60, ok);
      chk("out_valid", ok, 1);
      chk("out_data", out_data, tbl[r].res);
      chk("out_id", out_frame_id, 8'(r));
      fl = (flen_q.size() > 0) ? flen_q.pop_front() : -1;
      chk("fed_cycles", 64'(fl), 64'(tbl[r].cyc));
      pop();
      chk("idle_busy", busy, 0);
    end

    for (int f = 0; f < 4; f++) begin
      send_frame(1, 1, 0, 40, ok);
      chk("credit_start", ok, 1);
    end
    seen = 1'b0;
    in_valid = 1'b1;
    repeat (60) begin
      tick();
      if (in_ready) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("credit_block", seen, 0);
    chk("credit_starts", 64'(start_cnt), 64'd9);
    chk("hold_data", out_data, ONE2);
    chk("hold_id", out_frame_id, 8'd5);
    chk("full_busy", busy, 1);

    fork
      begin
        send_frame(1, 1, 0, 300, ok1);
        send_frame(1, 1, 0, 300, ok2);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          bit okw;
          wait_out(300, okw);
          chk("drain_valid", okw, 1);
          chk("drain_id", out_frame_id, 64'(8'(5 + k)));
          chk("drain_data", out_data, ONE2);
          pop();
        end
      end
    join
    chk("late_frame4", ok1, 1);
    chk("late_frame5", ok2, 1);
    chk("total_starts", 64'(start_cnt), 64'd11);

    chk("pre_seq_err", seq_err, 0);
    stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    chk("stray_seq_err", seq_err, 1);
    tick();
    chk("stray_out_valid", out_valid, 0);
    chk("stray_busy", busy, 0);

    send_frame(1, 1, 0, 40, ok);
    send_frame(1, 1, 0, 40, ok);
    send_frame(20, 5, 0, 40, ok);
    chk("mid_run_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_acc_start", acc_start, 0);
    chk("mr_acc_stop", acc_stop, 0);
    chk("mr_acc_in", acc_in, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_out_id", out_frame_id, 0);
    chk("mr_busy", busy, 0);
    chk("mr_seq_err", seq_err, 0);
    flen_q.delete();
    #12 reset = 1'b1;
    tick();

    send_frame(12, 12, 0, 40, ok);
    chk("post_rst_accept", ok, 1);
    wait_out(60, ok);
    chk("post_rst_valid", ok, 1);
    chk("post_rst_data", out_data, 64'h41400000_41C00000);
    chk("post_rst_id", out_frame_id, 0);
    fl = (flen_q.size() > 0) ? flen_q.pop_front() : -1;
    chk("post_rst_cycles", 64'(fl), 64'd12);
    pop();
    chk("acc_protocol", err_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
